// File: rtl/cla_pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   DEF_WIDTH   : default operand/result width
//   DEF_GROUP   : default lookahead group width (bits resolved per stage)
//   calc_stages : pipeline depth for a given width/group split
//   flags_t     : status flags registered alongside the final sum
// -----------------------------------------------------------------------------
package cla_pipe_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_GROUP = 4;

   // One group is resolved per stage, so depth is simply the group count.
   function automatic int calc_stages(input int width, input int group);
      return width / group;
   endfunction

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

endpackage

// File: rtl/cla_pipe_adder_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Combinational GROUP-bit carry-lookahead cell. Every internal carry is the
// fully expanded generate/propagate sum-of-products, so no carry ripples
// inside the group.
//   a, b  : group operand slices (b already inverted for subtraction)
//   c_in  : carry into the group
//   sum   : group sum slice
//   c_out : carry out of the group
//   gp    : group propagate (AND of all bit propagates)
//   gg    : group generate (carry out assuming c_in = 0)
// -----------------------------------------------------------------------------
module cla_group
   import cla_pipe_adder_pkg::*;
#(
   parameter int GROUP = DEF_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             c_in,
   output logic [GROUP-1:0] sum,
   output logic             c_out,
   output logic             gp,
   output logic             gg
);

   generate
      if (GROUP < 1) begin : g_bad_group
         $error("cla_group: GROUP must be at least 1");
      end
   endgenerate

   logic [GROUP-1:0] p;
   logic [GROUP-1:0] g;
   logic [GROUP:0]   carry;
   logic             gen_acc;
   logic             prop_acc;

   assign p = a ^ b;
   assign g = a & b;

   // carry[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c_in.
   // gen_acc collects the generate terms from the top bit downward while
   // prop_acc accumulates the running propagate product that gates them.
   always_comb begin
      carry    = '0;
      carry[0] = c_in;
      gen_acc  = 1'b0;
      prop_acc = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
         gen_acc  = g[i];
         prop_acc = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            gen_acc  = gen_acc | (prop_acc & g[j]);
            prop_acc = prop_acc & p[j];
         end
         carry[i+1] = gen_acc | (prop_acc & c_in);
      end
   end

   // After the last iteration the accumulators hold the whole-group terms.
   assign sum   = p ^ carry[GROUP-1:0];
   assign c_out = carry[GROUP];
   assign gp    = prop_acc;
   assign gg    = gen_acc;

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Stage k resolves lookahead group k; the group carry moves forward through
// a register each cycle, and the upper operand slices travel alongside it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : input handshake (in_ready = pipeline may advance)
//   a, b, sub, cin      : operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid, out_ready: output handshake
//   sum, cout, ovf, zero: result and flags (cout=1 on sub means no borrow)
// Latency is STAGES cycles from acceptance to out_valid; throughput 1/cycle.
// -----------------------------------------------------------------------------
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GROUP = DEF_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = calc_stages(WIDTH, GROUP);

   generate
      if ((GROUP < 1) || (WIDTH < GROUP) || ((WIDTH % GROUP) != 0)) begin : g_bad_width
         $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
      end
   endgenerate

   // Stage registers: entry k feeds the lookahead cell for group k.
   logic [WIDTH-1:0]  a_reg     [STAGES];
   logic [WIDTH-1:0]  a_next    [STAGES];
   logic [WIDTH-1:0]  b_reg     [STAGES];
   logic [WIDTH-1:0]  b_next    [STAGES];
   logic [WIDTH-1:0]  sum_reg   [STAGES];
   logic [WIDTH-1:0]  sum_next  [STAGES];
   logic [STAGES-1:0] carry_reg;
   logic [STAGES-1:0] carry_next;
   logic [STAGES-1:0] valid_reg;
   logic [STAGES-1:0] valid_next;

   // Output registers.
   logic [WIDTH-1:0]  res_reg;
   logic [WIDTH-1:0]  res_next;
   flags_t            flags_reg;
   flags_t            flags_next;
   logic              out_valid_reg;
   logic              out_valid_next;

   // Per-stage lookahead results.
   logic [GROUP-1:0]  grp_sum   [STAGES];
   logic [STAGES-1:0] grp_cout;
   logic [STAGES-1:0] grp_gp;
   logic [STAGES-1:0] grp_gg;

   logic adv;
   logic msb_carry;

   // The whole pipe moves in lockstep; an empty output slot or a consuming
   // downstream lets everything shift, bubbles included.
   assign adv      = ~out_valid_reg | out_ready;
   assign in_ready = adv;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         cla_group #(
            .GROUP (GROUP)
         ) u_group (
            .a     (a_reg[gi][gi*GROUP +: GROUP]),
            .b     (b_reg[gi][gi*GROUP +: GROUP]),
            .c_in  (carry_reg[gi]),
            .sum   (grp_sum[gi]),
            .c_out (grp_cout[gi]),
            .gp    (grp_gp[gi]),
            .gg    (grp_gg[gi])
         );
      end
   endgenerate

   // Group P/G are not needed here: the cell already folds c_in into c_out.
   logic unused_group_pg;
   assign unused_group_pg = ^{grp_gp, grp_gg};

   always_comb begin
      // Stage 0 loads the operands; subtraction is a + ~b + 1.
      a_next[0]     = a;
      b_next[0]     = sub ? ~b : b;
      sum_next[0]   = '0;
      carry_next[0] = sub | cin;
      valid_next[0] = in_valid;

      // Each later stage takes its predecessor's operands, the lower sum
      // slices resolved so far plus the slice just produced, and its carry.
      for (int k = 1; k < STAGES; k++) begin
         a_next[k]                        = a_reg[k-1];
         b_next[k]                        = b_reg[k-1];
         sum_next[k]                      = sum_reg[k-1];
         sum_next[k][(k-1)*GROUP +: GROUP] = grp_sum[k-1];
         carry_next[k]                    = grp_cout[k-1];
         valid_next[k]                    = valid_reg[k-1];
      end

      res_next                        = sum_reg[STAGES-1];
      res_next[WIDTH-GROUP +: GROUP]  = grp_sum[STAGES-1];

      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      msb_carry = res_next[WIDTH-1] ^ a_reg[STAGES-1][WIDTH-1] ^ b_reg[STAGES-1][WIDTH-1];

      flags_next.cout = grp_cout[STAGES-1];
      flags_next.ovf  = msb_carry ^ grp_cout[STAGES-1];
      flags_next.zero = (res_next == '0);
      out_valid_next  = valid_reg[STAGES-1];
   end

   // Data registers are cleared too so outputs never show X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]   <= '0;
            b_reg[k]   <= '0;
            sum_reg[k] <= '0;
         end
         carry_reg     <= '0;
         valid_reg     <= '0;
         res_reg       <= '0;
         flags_reg     <= '0;
         out_valid_reg <= 1'b0;
      end else if (adv) begin
         a_reg         <= a_next;
         b_reg         <= b_next;
         sum_reg       <= sum_next;
         carry_reg     <= carry_next;
         valid_reg     <= valid_next;
         res_reg       <= res_next;
         flags_reg     <= flags_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign sum       = res_reg;
   assign cout      = flags_reg.cout;
   assign ovf       = flags_reg.ovf;
   assign zero      = flags_reg.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Directed and random stimulus for cla_pipe_adder (WIDTH=32, GROUP=4) with a
// scoreboard fed by an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

   localparam int WIDTH = 32;
   localparam int GROUP = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   total    = 0;
   int   bad      = 0;
   int   accepted = 0;
   int   retired  = 0;

   cla_pipe_adder #(
      .WIDTH (WIDTH),
      .GROUP (GROUP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // Reference: plain integer arithmetic on signed/unsigned interpretations.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic s, input logic c);
      exp_t            e;
      longint          sr;
      longint unsigned ur;
      longint          max_s;
      longint          min_s;
      max_s = 64'sd2147483647;
      min_s = -64'sd2147483648;
      if (s) begin
         sr     = longint'($signed(x)) - longint'($signed(y));
         e.sum  = x - y;
         e.cout = (x >= y);
      end else begin
         sr     = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
         ur     = longint'(x) + longint'(y) + longint'(c);
         e.sum  = ur[31:0];
         e.cout = ur[32];
      end
      e.ovf  = (sr > max_s) || (sr < min_s);
      e.zero = (e.sum == 32'd0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: retire/accept according to the handshake seen this cycle,
   // then advance to 1 time unit after the next rising edge.
   task automatic tick();
      logic acc;
      logic ret;
      exp_t e;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
         check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            retired++;
            check("sum", 64'(sum), 64'(e.sum));
            check("cout", 64'(cout), 64'(e.cout));
            check("ovf", 64'(ovf), 64'(e.ovf));
            check("zero", 64'(zero), 64'(e.zero));
            $display("retire #%0d sum=%08h cout=%0b ovf=%0b zero=%0b", retired, sum, cout, ovf, zero);
         end
      end
      if (acc) begin
         sb.push_back(model(a, b, sub, cin));
         accepted++;
         $display("accept #%0d a=%08h b=%08h sub=%0b cin=%0b", accepted, a, b, sub, cin);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
      in_valid = 1'b1;
      a        = x;
      b        = y;
      sub      = s;
      cin      = c;
   endtask

   task automatic drive_rand();
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_complete", 64'(sb.size()), 64'd0);
      check("idle_after_drain", 64'(out_valid), 64'd0);
   endtask

   logic [31:0] va [4];
   logic [31:0] vb [4];
   logic        vs [4];
   logic [31:0] hold_sum;
   logic        hold_cout;
   logic        hold_ovf;
   logic        hold_zero;
   int          r0;

   initial begin
      va = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      vb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
      vs = '{1'b0, 1'b0, 1'b0, 1'b1};

      // Reset state
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      cin       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_sum", 64'(sum), 64'd0);
      check("reset_cout", 64'(cout), 64'd0);
      check("reset_ovf", 64'(ovf), 64'd0);
      check("reset_zero", 64'(zero), 64'd0);
      rst_n = 1'b1;
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);

      // Single beat 1+1: latency of exactly 8 edges
      drive(32'h1, 32'h1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("latency_quiet", 64'(out_valid), 64'd0);
         tick();
      end
      check("latency_valid", 64'(out_valid), 64'd1);
      check("first_sum", 64'(sum), 64'h2);
      drain(4);

      // Directed boundary vectors, one at a time
      for (int v = 1; v < 4; v++) begin
         drive(va[v], vb[v], vs[v], 1'b0);
         tick();
         drain(20);
      end

      // Back-to-back stream of 20 beats
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i < 4) drive(va[i], vb[i], vs[i], 1'b0);
         else       drive_rand();
         check("stream_out_valid", 64'(out_valid), 64'(i >= 9));
         tick();
      end
      drain(30);

      // Backpressure with a full pipeline
      for (int i = 0; i < 12; i++) begin
         drive_rand();
         tick();
      end
      out_ready = 1'b0;
      drive_rand();
      #1;
      hold_sum  = sum;
      hold_cout = cout;
      hold_ovf  = ovf;
      hold_zero = zero;
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_sum", 64'(sum), 64'(hold_sum));
         check("stall_flags", 64'({cout, ovf, zero}), 64'({hold_cout, hold_ovf, hold_zero}));
         tick();
      end
      out_ready = 1'b1;
      drain(40);
      check("beats_conserved", 64'(retired), 64'(accepted));

      // Reset with 4 beats in flight
      for (int i = 0; i < 4; i++) begin
         drive_rand();
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_out_valid", 64'(out_valid), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      check("rst_hold_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;
      r0 = retired;
      drive(32'd3, 32'd5, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("post_rst_quiet", 64'(out_valid), 64'd0);
         tick();
      end
      check("post_rst_valid", 64'(out_valid), 64'd1);
      check("post_rst_sum", 64'(sum), 64'd8);
      for (int i = 0; i < 6; i++) tick();
      check("post_rst_single", 64'(retired - r0), 64'd1);
      check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. Operands are split into GROUP-bit lookahead groups; one group resolves per pipeline stage, and the group carry ripples stage-to-stage through registers. Valid/ready handshakes on input and output allow the block to sit between the operand-fetch and writeback stages with backpressure.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of GROUP.
GROUP, 4, bits per lookahead group; also bits resolved per pipeline stage.
STAGES, WIDTH/GROUP, derived localparam; pipeline depth and latency in cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: a+b+cin; 1: a+~b+1 (cin ignored)
cin  input  1  carry-in for add mode
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (for sub: 1 means no borrow)
ovf  output  1  signed overflow = carry into MSB XOR cout
zero  output  1  sum == 0

Behaviour:
- Reset (rst_n low, async): all stage valid bits, sum, cout, ovf, zero clear to 0; in_ready reads 1 once rst_n is high again.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv. Input beat is accepted when in_valid & adv.
- On adv, every stage register shifts forward by one. Stage 0 captures a, b' (b or ~b), carry (cin or 1 if sub), and in_valid & adv as valid.
- When adv = 0, the whole pipeline holds, and sum, cout, ovf, zero stay stable while out_valid = 1. Bubbles are not collapsed.
- Stage k (0..STAGES-1): computes group k bits [k*GROUP +: GROUP] with full lookahead. Per-bit p = a^b', g = a&b'. c_i+1 = g_i | p_i&c_i, fully expanded within the group. Group P = AND of p, group G = lookahead expression. Outputs group sum and group carry-out.
- Stage k registers the following: its sum slice; its carry-out; remaining operand slices; already-resolved lower sum slices; valid. Upper operand slices are carried unmodified (skew buffer).
- Latency: a beat accepted at edge N produces out_valid = 1 after edge N+STAGES when there is no stall. Throughput is 1 beat/cycle.
- Final stage also registers the carry into the MSB to form ovf, and computes zero from the full sum.
- Simultaneous events: out_ready & in_valid in the same cycle with a full pipeline must accept and retire together, with no lost or duplicated beat.
- Reset mid-operation: all in-flight beats are discarded. No out_valid may appear after reset until new beats are accepted.
- Data outputs with out_valid = 0 are don't-care, but must not be X after reset.
- WIDTH % GROUP != 0 is an elaboration error (generate-time check).

Decomposition:
- Shared include header holds default WIDTH/GROUP constants and a function computing STAGES.
- One sub-module: cla_group. It is a combinational GROUP-bit lookahead cell with inputs a, b, c_in and outputs sum, c_out, gp, gg, and is instantiated once per stage via generate. All registers live in cla_pipe_adder.

Test Plan:
- WIDTH=32, GROUP=4. Reset, then a=0x0000_0001, b=0x0000_0001, sub=0, cin=0, out_ready=1 -> after 8 cycles: sum=0x0000_0002, cout=0, ovf=0, zero=0.
- a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x0000_0000, cout=1, ovf=0, zero=1. This checks a carry rippling through all 8 stages.
- a=0x7FFF_FFFF, b=0x0000_0001 add -> sum=0x8000_0000, ovf=1, cout=0. Then a=0x8000_0000, b=0x0000_0001, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back: stream 20 beats with in_valid=1 and out_ready=1; operand pairs are random plus the vectors above -> results appear in order, 1 per cycle, starting at cycle 8. Scoreboard must match.
- Backpressure: fill the pipeline, then hold out_ready=0 for 5 cycles -> in_ready=0 and sum/out_valid stable. Release -> all beats drain in order with none lost.
- Reset mid-stream: assert rst_n=0 with 4 beats in flight -> out_valid=0 immediately. After release, one new beat (3+5) -> a single result of sum=8, with no stale beats.
